// File: rtl/reverse_complement_stack.sv
`default_nettype none
// ============================================================================
//  Module      : reverse_complement_stack
//  Description : Buffers an ASCII base segment in a LIFO and replays it
//                reversed and complemented (A<->T, G<->C).
//  Revision    : 1.0 - initial release
// ============================================================================
module reverse_complement_stack #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:7] in_base,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [0:7] out_complement,
    output logic       out_last,
    output logic       out_error,
    output logic       overflow
);

    localparam logic [7:0]      c_idle_code = 8'h1F;
    localparam logic [7:0]      c_bad_code  = 8'hF1;
    localparam logic [ADDR_W:0] c_one       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_two       = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] c_full_m1   = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_comp_q, out_comp_d;
    logic              out_last_q, out_last_d;
    logic              out_error_q, out_error_d;
    logic [7:0]        mem_q [DEPTH];

    logic              w_push;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_next_top_idx;
    logic [8:0]        w_comp_in;
    logic [8:0]        w_comp_mem;

    // Returns {error, complemented byte}.
    function automatic logic [8:0] complement(input logic [7:0] b);
        case (b)
            8'h41:   return {1'b0, 8'h54};
            8'h54:   return {1'b0, 8'h41};
            8'h47:   return {1'b0, 8'h43};
            8'h43:   return {1'b0, 8'h47};
            default: return {1'b1, c_bad_code};
        endcase
    endfunction

    assign in_ready       = (state_q == FILL) && !reset;
    assign out_valid      = out_valid_q;
    assign out_complement = out_comp_q;
    assign out_last       = out_last_q;
    assign out_error      = out_error_q;
    assign overflow       = overflow_q;

    assign w_wr_idx       = count_q[ADDR_W-1:0];
    // Entry that becomes the top after the current top is popped.
    assign w_next_top_idx = count_q[ADDR_W-1:0] - ADDR_W'(2);
    assign w_comp_in      = complement(in_base);
    assign w_comp_mem     = complement(mem_q[w_next_top_idx]);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_comp_d  = out_comp_q;
        out_last_d  = out_last_q;
        out_error_d = out_error_q;
        w_push      = 1'b0;

        case (state_q)
            FILL: begin
                if (in_valid && in_ready) begin
                    w_push  = 1'b1;
                    count_d = count_q + c_one;
                    if (in_last || (count_q == c_full_m1)) begin
                        state_d     = DRAIN;
                        overflow_d  = overflow_q | !in_last;
                        // The just-accepted base is the new top; bypass the memory.
                        out_valid_d = 1'b1;
                        out_comp_d  = w_comp_in[7:0];
                        out_error_d = w_comp_in[8];
                        out_last_d  = (count_q == '0);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    count_d = count_q - c_one;
                    if (count_q == c_one) begin
                        state_d     = FILL;
                        out_valid_d = 1'b0;
                        out_comp_d  = c_idle_code;
                        out_error_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_comp_d  = w_comp_mem[7:0];
                        out_error_d = w_comp_mem[8];
                        out_last_d  = (count_q == c_two);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_comp_q  <= c_idle_code;
            out_last_q  <= 1'b0;
            out_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_comp_q  <= out_comp_d;
            out_last_q  <= out_last_d;
            out_error_q <= out_error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[w_wr_idx] <= in_base;
        end
    end

endmodule
`default_nettype wire
